hyper_xfer_sequencer: RTL and testbench
=======================================

// Module: hyper_xfer_sequencer
// PURPOSE
//  Upstream command source for hyper_lsab_dram. Takes one transfer descriptor
//  (start word address, length in words, LSAB section). Splits it into block
//  commands of at most MAX_BLOCK words and issues them over the GO/READY
//  interface. Re-issues after page-end restarts and short counts until the
//  whole length has been moved, then reports completion or an error.
// PARAMETERS
//  MAX_BLOCK  63    largest BLOCK_LENGTH issued (1..63)
//  MAX_STALL  4     consecutive zero-count commands tolerated before error
//  TIMEOUT    1023  cycles allowed in S_ISSUE or S_WAIT before error
// PORTS
//  CLK           in   1   fabric clock (CLK_n domain)
//  RST           in   1   asynchronous reset, active low
//  START         in   1   one-cycle pulse; latches DESC_* when idle
//  DESC_ADDR     in   32  start word address
//  DESC_LEN      in   16  transfer length in words
//  DESC_SECTION  in   2   LSAB section
//  ABORT         in   1   level; stop after the in-flight command
//  BUSY          out  1   high from accepted START until DONE
//  DONE          out  1   one-cycle completion pulse
//  ERR_CODE      out  2   0 none, 1 stall, 2 timeout, 3 addr mismatch; sticky to next START
//  REMAINING     out  16  words still to move
//  CUR_ADDR      out  32  address of the next command
//  GO            out  1   command strobe to hyper_lsab_dram
//  BLOCK_LENGTH  out  6   min(REMAINING, MAX_BLOCK)
//  NEW_ADDR      out  32  equals CUR_ADDR
//  NEW_SECTION   out  2   latched DESC_SECTION
//  OLD_ADDR      in   32  end address reported by hyper_lsab_dram
//  READY         in   1   high when hyper_lsab_dram is idle
//  RESTART_OP    in   1   command ended at page boundary
//  COUNT_SENT    in   6   words moved by the last command
// BEHAVIOUR
//  Reset: every output is 0; state S_IDLE; stall and timeout counters are 0.
//  S_IDLE
//  - START with DESC_LEN=0: DONE pulses next cycle. No GO is issued.
//  - START with DESC_LEN>0: latch the descriptor; BUSY=1; go to S_ISSUE.
//  - START while BUSY is ignored.
//  S_ISSUE
//  - GO=1 with BLOCK_LENGTH, NEW_ADDR and NEW_SECTION held stable.
//  - On READY=0: drop GO next cycle and go to S_WAIT.
//  S_WAIT
//  - On the READY rising edge (0->1), sample COUNT_SENT and RESTART_OP,
//    then go to S_ACCT.
//  S_ACCT (one cycle; OLD_ADDR is valid here, one cycle after the edge)
//  - CUR_ADDR += COUNT_SENT (zero-extended, mod 2^32).
//  - REMAINING -= COUNT_SENT, saturating at 0.
//  - COUNT_SENT=0: stall counter +1; otherwise cleared.
//  - RESTART_OP needs no special handling; the next command starts at the
//    updated CUR_ADDR.
//  - Priority of the next state, highest first:
//    1. stall counter = MAX_STALL: ERR_CODE=1, go to S_DONE.
//    2. REMAINING = 0, or ABORT high: go to S_DONE.
//    3. Otherwise go to S_ISSUE.
//  S_DONE
//  - DONE=1 and BUSY=0 for one cycle, then S_IDLE.
//  - An abort is visible as DONE with ERR_CODE=0 and REMAINING != 0.
//  Timeout
//  - The counter runs in S_ISSUE and S_WAIT and clears on every state change.
//  - Reaching TIMEOUT: ERR_CODE=2, GO=0, go to S_DONE.
//  ABORT
//  - Never cuts short a command whose GO has been accepted.
//  - Asserted in S_ISSUE before READY falls: the command is still accepted.
//  Async reset mid-transfer returns to S_IDLE immediately. The block mover is
//  reset separately.
//  BLOCK_LENGTH is registered and recomputed on entry to S_ISSUE.
// CONFIGURATION
//  ADDR_CHECK_EN defined:
//  - In S_ACCT, compare OLD_ADDR with the updated CUR_ADDR.
//  - Mismatch: ERR_CODE=3, go to S_DONE. This outranks the stall error.
//  ADDR_CHECK_EN undefined: OLD_ADDR is ignored and the compare logic is absent.
// TESTING
//  1 ADDR=0x0020_0001, LEN=3; mover sends 3 -> one GO with BLOCK_LENGTH=3;
//    DONE; REMAINING=0; CUR_ADDR=0x0020_0004; ERR_CODE=0.
//  2 ADDR=0x0020_0fff, LEN=3; mover sends 1 with RESTART_OP=1, then 2 ->
//    second GO has NEW_ADDR=0x0020_1000, BLOCK_LENGTH=2; then DONE.
//  3 ADDR=0x0020_1001, LEN=200; full counts -> BLOCK_LENGTH sequence
//    63,63,63,11; DONE; CUR_ADDR=0x0020_10c9.
//  4 Mover always returns COUNT_SENT=0, LEN=10 -> 4 GOs; then DONE with
//    ERR_CODE=1 and REMAINING=10.
//  5 READY held high after GO -> DONE at TIMEOUT; ERR_CODE=2; GO=0.
//    ABORT during the 2nd command of test 3 -> DONE after it with REMAINING=74.
//  6 ADDR_CHECK_EN: OLD_ADDR off by +1 -> ERR_CODE=3 after the first command.
//    Also: START with LEN=0 -> DONE next cycle, no GO.

Source files
------------

// File: rtl/hyper_xfer_if.sv
// Command/descriptor bundle between the transfer sequencer and its
// descriptor source and block mover (hyper_lsab_dram).
interface hyper_xfer_if;
    logic        start;
    logic [31:0] desc_addr;
    logic [15:0] desc_len;
    logic [1:0]  desc_section;
    logic        abort;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [15:0] remaining;
    logic [31:0] cur_addr;
    logic        go;
    logic [5:0]  block_length;
    logic [31:0] new_addr;
    logic [1:0]  new_section;
    logic [31:0] old_addr;
    logic        ready;
    logic        restart_op;
    logic [5:0]  count_sent;

    modport master (
        input  start, desc_addr, desc_len, desc_section, abort,
        input  old_addr, ready, restart_op, count_sent,
        output busy, done, err_code, remaining, cur_addr,
        output go, block_length, new_addr, new_section
    );

    modport slave (
        output start, desc_addr, desc_len, desc_section, abort,
        output old_addr, ready, restart_op, count_sent,
        input  busy, done, err_code, remaining, cur_addr,
        input  go, block_length, new_addr, new_section
    );
endinterface

// File: rtl/hyper_xfer_sequencer.sv
// Splits one transfer descriptor into GO/READY block commands for hyper_lsab_dram.
// Optional ADDR_CHECK_EN: cross-check the mover's end address after each command.
module hyper_xfer_sequencer #(
    parameter int MAX_BLOCK = 63,
    parameter int MAX_STALL = 4,
    parameter int TIMEOUT   = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    hyper_xfer_if.master  bus
);
    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACCT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]         state_r;
    logic               busy_r;
    logic               done_r;
    logic [1:0]         err_r;
    logic [15:0]        rem_r;
    logic [31:0]        cur_r;
    logic               go_r;
    logic [5:0]         blk_r;
    logic [1:0]         sec_r;
    logic               ready_q_r;
    logic [5:0]         count_r;
    logic [STALL_W-1:0] stall_r;
    logic [TMO_W-1:0]   tmo_r;

    logic [31:0]        cur_upd_s;
    logic [15:0]        rem_upd_s;
    logic [STALL_W-1:0] stall_upd_s;
    logic               tmo_hit_s;
    logic               acct_done_s;
    logic [1:0]         acct_err_s;

    function automatic logic [5:0] blk_len(input logic [15:0] rem);
        if (rem > 16'(MAX_BLOCK)) begin
            return 6'(MAX_BLOCK);
        end else begin
            return rem[5:0];
        end
    endfunction

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.err_code     = err_r;
    assign bus.remaining    = rem_r;
    assign bus.cur_addr     = cur_r;
    assign bus.go           = go_r;
    assign bus.block_length = blk_r;
    assign bus.new_addr     = cur_r;
    assign bus.new_section  = sec_r;

    assign cur_upd_s   = cur_r + {26'd0, count_r};
    assign rem_upd_s   = (rem_r > {10'd0, count_r}) ? (rem_r - {10'd0, count_r}) : 16'd0;
    assign stall_upd_s = (count_r == 6'd0) ? (stall_r + STALL_W'(1)) : STALL_W'(0);
    assign tmo_hit_s   = (tmo_r == TMO_W'(TIMEOUT - 1));

    // Accounting outcome: address error outranks stall, which outranks completion/abort.
    always_comb begin
        acct_done_s = 1'b0;
        acct_err_s  = 2'd0;
`ifdef ADDR_CHECK_EN
        if (bus.old_addr != cur_upd_s) begin
            acct_done_s = 1'b1;
            acct_err_s  = 2'd3;
        end else
`endif
        if (stall_upd_s == STALL_W'(MAX_STALL)) begin
            acct_done_s = 1'b1;
            acct_err_s  = 2'd1;
        end else if ((rem_upd_s == 16'd0) || bus.abort) begin
            acct_done_s = 1'b1;
            acct_err_s  = 2'd0;
        end else begin
            acct_done_s = 1'b0;
            acct_err_s  = 2'd0;
        end
    end

    // Sequencer FSM and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 2'd0;
            rem_r     <= 16'd0;
            cur_r     <= 32'd0;
            go_r      <= 1'b0;
            blk_r     <= 6'd0;
            sec_r     <= 2'd0;
            ready_q_r <= 1'b0;
            count_r   <= 6'd0;
            stall_r   <= '0;
            tmo_r     <= '0;
        end else begin
            ready_q_r <= bus.ready;
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    tmo_r  <= '0;
                    if (bus.start) begin
                        err_r   <= 2'd0;
                        cur_r   <= bus.desc_addr;
                        rem_r   <= bus.desc_len;
                        sec_r   <= bus.desc_section;
                        stall_r <= '0;
                        if (bus.desc_len == 16'd0) begin
                            done_r  <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            busy_r  <= 1'b1;
                            go_r    <= 1'b1;
                            blk_r   <= blk_len(bus.desc_len);
                            state_r <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (tmo_hit_s) begin
                        err_r   <= 2'd2;
                        go_r    <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        tmo_r   <= '0;
                        state_r <= S_DONE;
                    end else if (!bus.ready) begin
                        go_r    <= 1'b0;
                        tmo_r   <= '0;
                        state_r <= S_WAIT;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                S_WAIT: begin
                    if (tmo_hit_s) begin
                        err_r   <= 2'd2;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        tmo_r   <= '0;
                        state_r <= S_DONE;
                    end else if (bus.ready && !ready_q_r) begin
                        count_r <= bus.count_sent;
                        tmo_r   <= '0;
                        state_r <= S_ACCT;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                S_ACCT: begin
                    // A page-end restart needs nothing extra: the next block starts at cur_upd_s.
                    cur_r   <= cur_upd_s;
                    rem_r   <= rem_upd_s;
                    stall_r <= stall_upd_s;
                    if (acct_done_s) begin
                        err_r   <= acct_err_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        go_r    <= 1'b1;
                        blk_r   <= blk_len(rem_upd_s);
                        state_r <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    go_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hyper_xfer_sequencer.sv
// Scoreboard bench for hyper_xfer_sequencer with a behavioural block-mover model.
module tb_hyper_xfer_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hyper_xfer_if bus ();

    hyper_xfer_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct { logic [5:0] bl; logic [31:0] addr; logic [1:0] sec; } go_t;
    typedef struct { logic [5:0] cnt; logic [31:0] old; logic rst_op; } stim_t;
    typedef struct { logic [1:0] err; logic [15:0] rem; logic [31:0] addr; } done_t;

    go_t   exp_go[$];
    stim_t stim_q[$];
    done_t exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_list[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 full counts, 1 always zero, 2 counts from cnt_list
    task automatic run_xfer(input string name, input logic [31:0] addr, input logic [15:0] len,
                            input logic [1:0] sec, input int mode, input int abort_at,
                            input bit hold, input logic [31:0] off, input bit inject);
        logic [15:0] rem = len;
        logic [31:0] cur = addr;
        logic [5:0]  bl, c;
        logic [1:0]  err = 2'd0;
        int          stall = 0;
        int          i = 0;
        int          cyc = 0;
        int          cmd = 0;
        bit          fin = 1'b0;
        go_t         g;
        stim_t       s;
        done_t       d;

        while (i < 200) begin
            bl = (rem > 16'd63) ? 6'd63 : rem[5:0];
            exp_go.push_back('{bl, cur, sec});
            if (hold) begin
                err = 2'd2;
                break;
            end
            c = (mode == 0) ? bl : (mode == 1) ? 6'd0 : 6'(cnt_list[i]);
            stim_q.push_back('{c, cur + {26'd0, c} + off, (c < bl)});
            cur   = cur + {26'd0, c};
            rem   = (rem > {10'd0, c}) ? rem - {10'd0, c} : 16'd0;
            stall = (c == 6'd0) ? stall + 1 : 0;
            i++;
`ifdef ADDR_CHECK_EN
            if (off != 32'd0) begin
                err = 2'd3;
                break;
            end
`endif
            if (stall == 4) begin
                err = 2'd1;
                break;
            end
            if (rem == 16'd0 || i == abort_at) break;
        end
        exp_done.push_back('{err, rem, cur});

        @(negedge clk);
        bus.start = 1'b1; bus.desc_addr = addr; bus.desc_len = len; bus.desc_section = sec;
        @(negedge clk);
        bus.start = 1'b0;
        while (!fin) begin
            if (cyc > 5000) begin
                chk({name, "_watchdog"}, 64'd0, 64'd1);
                fin = 1'b1;
            end else if (bus.done) begin
                if (exp_done.size() == 0) begin
                    chk({name, "_done_unexpected"}, 64'd1, 64'd0);
                end else begin
                    d = exp_done.pop_front();
                    chk({name, "_err"},  64'(bus.err_code),  64'(d.err));
                    chk({name, "_rem"},  64'(bus.remaining), 64'(d.rem));
                    chk({name, "_addr"}, 64'(bus.cur_addr),  64'(d.addr));
                    chk({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
                    chk({name, "_go_at_done"},   64'(bus.go),   64'd0);
                end
                bus.abort = 1'b0;
                fin = 1'b1;
            end else if (bus.go && bus.ready && !(hold && cmd > 0)) begin
                cmd++;
                if (exp_go.size() == 0) begin
                    chk({name, "_go_unexpected"}, 64'd1, 64'd0);
                end else begin
                    g = exp_go.pop_front();
                    chk({name, "_blen"}, 64'(bus.block_length), 64'(g.bl));
                    chk({name, "_naddr"}, 64'(bus.new_addr),    64'(g.addr));
                    chk({name, "_nsec"}, 64'(bus.new_section),  64'(g.sec));
                end
                if (cmd == abort_at) bus.abort = 1'b1;
                if (!hold && stim_q.size() != 0) begin
                    s = stim_q.pop_front();
                    bus.ready = 1'b0;
                    if (inject && cmd == 1) begin
                        bus.start = 1'b1; bus.desc_addr = 32'h0; bus.desc_len = 16'd5;
                    end
                    @(negedge clk);
                    bus.start = 1'b0;
                    cyc++;
                    @(negedge clk);
                    cyc++;
                    bus.count_sent = s.cnt; bus.old_addr = s.old; bus.restart_op = s.rst_op;
                    bus.ready = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        chk({name, "_go_left"}, 64'(exp_go.size()), 64'd0);
        exp_go.delete(); stim_q.delete(); exp_done.delete();
        bus.ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.desc_addr = 32'd0; bus.desc_len = 16'd0; bus.desc_section = 2'd0;
        bus.abort = 1'b0; bus.old_addr = 32'd0; bus.ready = 1'b1; bus.restart_op = 1'b0;
        bus.count_sent = 6'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_err",  64'(bus.err_code), 64'd0);
        chk("rst_rem",  64'(bus.remaining), 64'd0);
        chk("rst_addr", 64'(bus.cur_addr), 64'd0);
        chk("rst_go",   64'(bus.go), 64'd0);
        chk("rst_blen", 64'(bus.block_length), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_xfer("t1", 32'h0020_0001, 16'd3, 2'd1, 0, 0, 1'b0, 32'd0, 1'b0);
        cnt_list[0] = 1; cnt_list[1] = 2;
        run_xfer("t2", 32'h0020_0fff, 16'd3, 2'd2, 2, 0, 1'b0, 32'd0, 1'b0);
        run_xfer("t3", 32'h0020_1001, 16'd200, 2'd3, 0, 0, 1'b0, 32'd0, 1'b0);
        run_xfer("t4", 32'h0000_0100, 16'd10, 2'd0, 1, 0, 1'b0, 32'd0, 1'b0);
        run_xfer("t5", 32'h0000_4000, 16'd20, 2'd1, 0, 0, 1'b1, 32'd0, 1'b0);
        run_xfer("t5ab", 32'h0020_1001, 16'd200, 2'd3, 0, 2, 1'b0, 32'd0, 1'b1);
        run_xfer("t6", 32'h0030_0000, 16'd70, 2'd2, 0, 0, 1'b0, 32'd1, 1'b0);

        // zero-length descriptor: DONE on the following cycle, never a GO
        @(negedge clk);
        bus.start = 1'b1; bus.desc_addr = 32'h0000_1234; bus.desc_len = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        chk("len0_done", 64'(bus.done), 64'd1);
        chk("len0_go",   64'(bus.go), 64'd0);
        chk("len0_err",  64'(bus.err_code), 64'd0);
        @(negedge clk);
        chk("len0_done_clr", 64'(bus.done), 64'd0);
        chk("len0_go2",      64'(bus.go), 64'd0);

        // async reset in the middle of a transfer
        @(negedge clk);
        bus.start = 1'b1; bus.desc_addr = 32'h0000_0040; bus.desc_len = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mid_busy", 64'(bus.busy), 64'd1);
        chk("mid_go",   64'(bus.go), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_go",   64'(bus.go), 64'd0);
        chk("mid_rst_rem",  64'(bus.remaining), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
